baud_gen_frac: RTL and testbench
================================

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz (used only for reset divisor).
REQ-002 Parameter BAUDRATE, default 9600, reset-default baud rate.
REQ-003 Parameter OVERSAMPLE, default 16, ticks per bit; legal range 4..64, even.
REQ-004 Parameter DIV_W, default 16, integer divisor width.
REQ-005 Parameter FRAC_W, default 4, fractional divisor width.
REQ-006 clk  input  1  system clock; the block has one clock, all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 en  input  1  count enable; 0 freezes all counters.
REQ-009 phase_clr  input  1  single-cycle pulse; restarts bit phase (RX start-bit alignment).
REQ-010 div_int  input  DIV_W  integer part of clocks per oversample tick.
REQ-011 div_frac  input  FRAC_W  fractional part, units of 1/2^FRAC_W clock.
REQ-012 div_load  input  1  single-cycle pulse; captures div_int/div_frac.
REQ-013 tick  output  1  oversample tick, one-cycle registered pulse.
REQ-014 mid_tick  output  1  one-cycle pulse at bit centre.
REQ-015 bit_tick  output  1  one-cycle pulse at bit end.
REQ-016 cfg_pending  output  1  captured divisor not yet applied.

Function
REQ-017 Active divisor (D_int, D_frac) SHALL set tick period L = D_int + c cycles, c = carry of the fractional accumulator; long-run mean period = D_int + D_frac/2^FRAC_W.
REQ-018 Clock counter cnt SHALL count 0..L-1 while en=1; tick SHALL be registered high for exactly one cycle in the cycle after cnt==L-1, so tick pulses are spaced L cycles apart.
REQ-019 At each tick boundary {c, acc} <= acc + D_frac (FRAC_W+1-bit sum); the resulting c sets the length of the following period only; first period after reset/phase_clr uses c=0.
REQ-020 D_int values 0 or 1 SHALL be clamped to 2 at capture.
REQ-021 Oversample counter os_cnt SHALL advance 0..OVERSAMPLE-1 on each tick, wrapping to 0.
REQ-022 bit_tick SHALL assert coincident with the tick on which os_cnt wraps from OVERSAMPLE-1 to 0.
REQ-023 mid_tick SHALL assert coincident with the tick on which os_cnt goes from OVERSAMPLE/2-1 to OVERSAMPLE/2.
REQ-024 div_load SHALL capture inputs into a shadow register and set cfg_pending=1 the next cycle.
REQ-025 Shadow SHALL be applied at the next tick boundary (cnt==L-1 with en=1), clearing cfg_pending in the same edge; if en=0 or phase_clr=1 it SHALL be applied immediately.
REQ-026 A second div_load while pending SHALL overwrite the shadow; last value wins.
REQ-027 en=0: cnt, os_cnt, acc hold; tick/mid_tick/bit_tick SHALL be 0 from the next cycle; counting resumes from held state when en returns to 1.
REQ-028 phase_clr SHALL clear cnt, os_cnt, acc at the next edge, suppress any tick that edge, and take priority over en and over a coincident tick boundary.
REQ-029 phase_clr and div_load in the same cycle: new divisor SHALL be active for the first period after the clear.
REQ-030 Arithmetic SHALL be unsigned, cnt width DIV_W+1 to hold D_int; no overflow at D_int = 2^DIV_W-1.

Reset
REQ-031 On rst=1 at a clock edge: cnt=0, os_cnt=0, acc=0, tick=0, mid_tick=0, bit_tick=0, cfg_pending=0, shadow cleared.
REQ-032 Reset divisor SHALL be Q = floor(CLK_HZ*2^FRAC_W/(BAUDRATE*OVERSAMPLE)), D_int = Q>>FRAC_W, D_frac = Q mod 2^FRAC_W (defaults: 651, 0).
REQ-033 rst SHALL override en, phase_clr and div_load; reset mid-period discards the partial period and any pending load.

Verification
REQ-034 Defaults, en=1 after reset -> tick spacing 651 clocks, bit_tick every 10416 clocks, mid_tick 5208 clocks after each bit_tick.
REQ-035 OVERSAMPLE=4, load div_int=4, div_frac=8, en=0 then en=1 -> tick spacings 4,4,5,4,5,4,5; bit_tick every 4th tick; cfg_pending pulses high one cycle only.
REQ-036 Running at div_int=10, div_load div_int=3 mid-period -> cfg_pending=1 until current 10-cycle period ends, next spacing 3.
REQ-037 div_load div_int=1 -> spacing 2; div_int=0 -> spacing 2.
REQ-038 phase_clr 2 cycles before a scheduled tick, os_cnt=7 -> that tick suppressed, next tick exactly L cycles after clear, os_cnt restarts at 0, no bit_tick.
REQ-039 rst asserted mid-period with load pending -> all outputs 0 next cycle, cfg_pending=0, divisor back to 651/0.

Source files
------------

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: produces an oversample tick whose period
// dithers between D_int and D_int+1 clocks so that the long-run mean equals
// D_int + D_frac/2^FRAC_W. It also produces bit-centre and bit-end pulses
// derived from an oversample counter. The divisor is double-buffered and
// changes only on period boundaries.
module baud_gen_frac #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUDRATE   = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              phase_clr,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic              cfg_pending
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [63:0] RST_Q =
    (64'(CLK_HZ) << FRAC_W) / (64'(BAUDRATE) * 64'(OVERSAMPLE));
  localparam logic [DIV_W-1:0]  RST_Q_INT = DIV_W'(RST_Q >> FRAC_W);
  localparam logic [DIV_W-1:0]  RST_INT   = (RST_Q_INT < DIV_W'(2)) ? DIV_W'(2) : RST_Q_INT;
  localparam logic [FRAC_W-1:0] RST_FRAC  = FRAC_W'(RST_Q);

  // Divisors below 2 cannot produce a registered one-cycle pulse train.
  function automatic logic [DIV_W-1:0] clamp_int(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  logic [DIV_W:0]    cnt;
  logic [OS_W-1:0]   os_cnt;
  logic [FRAC_W-1:0] acc;
  logic              carry;
  logic [DIV_W-1:0]  act_int, sh_int, nxt_int;
  logic [FRAC_W-1:0] act_frac, sh_frac, nxt_frac;
  logic [DIV_W:0]    period_last;
  logic [FRAC_W:0]   acc_sum;
  logic              boundary;
  logic              apply_sh;

  // Period end detection and selection of the divisor in force after this edge.
  always_comb begin
    period_last = {1'b0, act_int} + {{DIV_W{1'b0}}, carry} - (DIV_W+1)'(1);
    // >= guards against a held count left beyond a freshly shortened period.
    boundary    = en && !phase_clr && (cnt >= period_last);
    apply_sh    = cfg_pending && (boundary || !en || phase_clr);
    nxt_int     = act_int;
    nxt_frac    = act_frac;
    if (phase_clr && div_load) begin
      nxt_int  = clamp_int(div_int);
      nxt_frac = div_frac;
    end else if (apply_sh) begin
      nxt_int  = sh_int;
      nxt_frac = sh_frac;
    end
    acc_sum = {1'b0, acc} + {1'b0, nxt_frac};
  end

  // Counters, fractional accumulator, output pulses and divisor shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      os_cnt      <= '0;
      acc         <= '0;
      carry       <= 1'b0;
      tick        <= 1'b0;
      mid_tick    <= 1'b0;
      bit_tick    <= 1'b0;
      cfg_pending <= 1'b0;
      sh_int      <= '0;
      sh_frac     <= '0;
      act_int     <= RST_INT;
      act_frac    <= RST_FRAC;
    end else begin
      act_int  <= nxt_int;
      act_frac <= nxt_frac;
      tick     <= boundary;
      mid_tick <= boundary && (os_cnt == OS_W'(OVERSAMPLE/2 - 1));
      bit_tick <= boundary && (os_cnt == OS_W'(OVERSAMPLE - 1));

      if (phase_clr) begin
        cnt    <= '0;
        os_cnt <= '0;
        acc    <= '0;
        carry  <= 1'b0;
      end else if (boundary) begin
        cnt            <= '0;
        os_cnt         <= (os_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt + OS_W'(1);
        {carry, acc}   <= acc_sum;
      end else if (en) begin
        cnt <= cnt + (DIV_W+1)'(1);
      end

      if (phase_clr) begin
        cfg_pending <= 1'b0;
      end else if (div_load) begin
        sh_int      <= clamp_int(div_int);
        sh_frac     <= div_frac;
        cfg_pending <= 1'b1;
      end else if (apply_sh) begin
        cfg_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: default-rate spacing, fractional dither
// tables, divisor shadowing, enable hold, phase clear and reset.
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        phase_clr = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        div_load = 1'b0;
  logic        tick, mid_tick, bit_tick, cfg_pending;
  logic        tick4, mid_tick4, bit_tick4, cfg_pending4;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  baud_gen_frac dut (
    .clk(clk), .rst(rst), .en(en), .phase_clr(phase_clr),
    .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
    .tick(tick), .mid_tick(mid_tick), .bit_tick(bit_tick), .cfg_pending(cfg_pending)
  );

  baud_gen_frac #(.OVERSAMPLE(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .phase_clr(phase_clr),
    .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
    .tick(tick4), .mid_tick(mid_tick4), .bit_tick(bit_tick4), .cfg_pending(cfg_pending4)
  );

  typedef struct {
    logic [15:0] di;
    logic [3:0]  df;
    int          sp[7];
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Steps negedges until tick is seen; a missed tick counts as a failure.
  task automatic wait_tick(input int budget, output int t);
    bit ok;
    ok = 1'b0;
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tick) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
    end
    if (!ok) chk("tick_timeout", 0, 1);
  endtask

  task automatic step_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int t, tp, t0, c0, k;
    int mid8, bit16, mid24, bit32;

    vecs[0].di = 16'd4; vecs[0].df = 4'd8;  vecs[0].sp = '{4, 4, 5, 4, 5, 4, 5};
    vecs[1].di = 16'd1; vecs[1].df = 4'd0;  vecs[1].sp = '{2, 2, 2, 2, 2, 2, 2};
    vecs[2].di = 16'd0; vecs[2].df = 4'd0;  vecs[2].sp = '{2, 2, 2, 2, 2, 2, 2};
    vecs[3].di = 16'd5; vecs[3].df = 4'd4;  vecs[3].sp = '{5, 5, 5, 5, 6, 5, 5};
    vecs[4].di = 16'd3; vecs[4].df = 4'd15; vecs[4].sp = '{3, 3, 4, 4, 4, 4, 4};
    mid8 = 0; bit16 = 0; mid24 = 0; bit32 = 0;

    // Reset, with other controls active to show rst dominates.
    en = 1'b1; div_load = 1'b1; div_int = 16'd7;
    repeat (3) @(negedge clk);
    chk("rst_tick", tick, 0);
    chk("rst_mid", mid_tick, 0);
    chk("rst_bit", bit_tick, 0);
    chk("rst_pending", cfg_pending, 0);
    div_load = 1'b0;

    // Default divisor 651/0 with 16x oversample.
    rst = 1'b0;
    tp = cyc;
    for (k = 1; k <= 39; k++) begin
      wait_tick(700, t);
      chk("def_spacing", t - tp, 651);
      chk("def_mid", mid_tick, (k % 16) == 8);
      chk("def_bit", bit_tick, (k % 16) == 0);
      if (k == 8)  mid8 = t;
      if (k == 16) bit16 = t;
      if (k == 24) mid24 = t;
      if (k == 32) bit32 = t;
      tp = t;
    end
    chk("def_bit_period", bit32 - bit16, 10416);
    chk("def_mid_after_bit", mid24 - bit16, 5208);
    chk("def_first_bit", bit16 - mid8, 5208);

    // Phase clear two edges before a scheduled tick, os_cnt at 7.
    step_to(tp + 649);
    phase_clr = 1'b1;
    @(negedge clk);
    phase_clr = 1'b0;
    c0 = cyc;
    chk("pclr_no_tick", tick, 0);
    wait_tick(700, t);
    chk("pclr_next_tick", t - c0, 651);
    chk("pclr_mid0", mid_tick, 0);
    chk("pclr_bit0", bit_tick, 0);
    for (int j = 1; j < 8; j++) begin
      wait_tick(700, t);
      chk("pclr_mid", mid_tick, j == 7);
      chk("pclr_bit", bit_tick, 0);
    end

    // Load 10 while running; applied at the end of the current period.
    div_int = 16'd10; div_frac = 4'd0; div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    chk("load10_pending", cfg_pending, 1);
    wait_tick(700, t);
    chk("load10_applied", cfg_pending, 0);
    tp = t;
    wait_tick(20, t);
    chk("sp10", t - tp, 10);
    tp = t;
    step_to(tp + 4);
    div_int = 16'd3; div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    chk("mid_load_pending_a", cfg_pending, 1);
    step_to(tp + 9);
    chk("mid_load_pending_b", cfg_pending, 1);
    wait_tick(20, t);
    chk("mid_load_old_period", t - tp, 10);
    chk("mid_load_cleared", cfg_pending, 0);
    tp = t;
    wait_tick(20, t);
    chk("mid_load_sp3", t - tp, 3);
    tp = t;
    wait_tick(20, t);
    chk("mid_load_sp3b", t - tp, 3);

    // Table: load with en=0 after a clear, then measure tick spacings.
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      en = 1'b0; phase_clr = 1'b1;
      @(negedge clk);
      phase_clr = 1'b0;
      div_int = vecs[v].di; div_frac = vecs[v].df; div_load = 1'b1;
      @(negedge clk);
      div_load = 1'b0;
      chk("tbl_pending_hi", cfg_pending, 1);
      @(negedge clk);
      chk("tbl_pending_lo", cfg_pending, 0);
      chk("tbl_idle_tick", tick, 0);
      en = 1'b1;
      tp = cyc;
      for (int i = 0; i < 7; i++) begin
        wait_tick(20, t);
        chk($sformatf("tbl%0d_sp%0d", v, i), t - tp, vecs[v].sp[i]);
        if (v == 0) chk("tbl_os4_bit", bit_tick4, i == 3);
        tp = t;
      end
    end

    // Clear and load in the same cycle: new divisor used right away.
    @(negedge clk);
    phase_clr = 1'b1; div_load = 1'b1; div_int = 16'd6; div_frac = 4'd0;
    @(negedge clk);
    phase_clr = 1'b0; div_load = 1'b0;
    c0 = cyc;
    chk("pclr_load_pending", cfg_pending, 0);
    wait_tick(20, t);
    chk("pclr_load_first", t - c0, 6);
    tp = t;
    wait_tick(20, t);
    chk("pclr_load_sp", t - tp, 6);
    tp = t;

    // Enable low for five edges mid-period: counters hold, no ticks.
    step_to(tp + 2);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("en0_no_tick", tick, 0);
    end
    en = 1'b1;
    wait_tick(20, t);
    chk("en_resume", t - tp, 11);
    tp = t;

    // Reset mid-period with a load pending: divisor returns to default.
    step_to(tp + 2);
    div_int = 16'd3; div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    chk("pre_rst_pending", cfg_pending, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_tick", tick, 0);
    chk("rst2_mid", mid_tick, 0);
    chk("rst2_bit", bit_tick, 0);
    chk("rst2_pending", cfg_pending, 0);
    rst = 1'b0;
    tp = cyc;
    wait_tick(700, t);
    chk("rst2_spacing", t - tp, 651);
    tp = t;
    wait_tick(700, t);
    chk("rst2_spacing_b", t - tp, 651);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
